// File: rtl/data_memory_responder.sv
// Multi-cycle data memory: one load/store in flight, completed LATENCY edges after
// acceptance with a registered ready pulse; illegal accesses are reported on error.
module data_memory_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE       = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        error
);

    // state | meaning
    // IDLE  | waiting for req; request captured when req=1
    // WAIT  | counting down the access latency
    // DONE  | final cycle; the array access and ready/error update happen on the edge leaving it
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN     = 33'(4 * WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic        accept, access;

    logic [31:0] addr_q, wdata_q;
    logic        we_q;

    logic [31:0] offset;
    logic        misaligned, out_of_range, illegal;
    logic [DEPTH_LOG2-1:0] index;

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    count_next = CNT_INIT;
                    state_next = (CNT_INIT == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                access     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            wdata_q <= writedata;
            we_q    <= memwrite;
        end
    end

    // Unsigned subtraction makes addresses below BASE wrap to huge offsets.
    assign offset       = addr_q - BASE;
    assign misaligned   = |addr_q[1:0];
    assign out_of_range = {1'b0, offset} >= SPAN;
    assign illegal      = misaligned | out_of_range;
    assign index        = offset[DEPTH_LOG2+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            ready    <= 1'b0;
            error    <= 1'b0;
            readdata <= 32'h0;
        end else begin
            ready <= access;
            error <= access & illegal;
            if (access && !we_q) begin
                readdata <= illegal ? 32'h0 : mem[index];
            end
        end
    end

    // A reset on the completing edge drops the pending store.
    always_ff @(posedge clk) begin
        if (!reset && access && we_q && !illegal) begin
            mem[index] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed vector table, hand-written
// timing sequences, and randomized traffic against a word-array reference model.
module tb_data_memory_responder;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = '0, wd2 = '0, rd2;
    logic        rdy2, err2;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wd1 = '0, rd1;
    logic        rdy1, err1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mdl [int];
    logic [31:0] mdl_rd = 32'h0;

    data_memory_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE(BASE)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .memwrite(we2), .addr(addr2),
        .writedata(wd2), .readdata(rd2), .ready(rdy2), .error(err2));

    data_memory_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE(BASE)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .memwrite(we1), .addr(addr1),
        .writedata(wd1), .readdata(rd1), .ready(rdy1), .error(err1));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] == 2'b00) && (off < 32'd4096);
    endfunction

    // Reference behaviour for the LATENCY=2 instance.
    task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] d,
                               output logic exp_err, output logic [31:0] exp_rd);
        int k;
        exp_err = !legal(a);
        k = int'((a - BASE) >> 2);
        if (we) begin
            if (legal(a)) mdl[k] = d;
        end else begin
            mdl_rd = legal(a) ? mdl[k] : 32'h0;
        end
        exp_rd = mdl_rd;
    endtask

    // Called #1 after an edge with the DUT idle; returns in the ready cycle.
    task automatic run_req(input bit sel, input logic we, input logic [31:0] a,
                           input logic [31:0] d, output int lat,
                           output logic [31:0] rd, output logic er);
        if (sel) begin req1 = 1'b1; we1 = we; addr1 = a; wd1 = d; end
        else     begin req2 = 1'b1; we2 = we; addr2 = a; wd2 = d; end
        @(posedge clk); #1;
        if (sel) begin req1 = 1'b0; we1 = !we; addr1 = $urandom; wd1 = $urandom; end
        else     begin req2 = 1'b0; we2 = !we; addr2 = $urandom; wd2 = $urandom; end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (((sel ? rdy1 : rdy2) !== 1'b1) && lat < 20);
        rd = sel ? rd1 : rd2;
        er = sel ? err1 : err2;
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d);
        int          lat;
        logic [31:0] rd, exp_rd;
        logic        er, exp_err;
        run_req(1'b0, we, a, d, lat, rd, er);
        model_apply(we, a, d, exp_err, exp_rd);
        chk("rand_latency", 32'(lat), 32'd2);
        chk("rand_error", 32'(er), 32'(exp_err));
        chk("rand_readdata", rd, exp_rd);
    endtask

    function automatic logic [31:0] pool_addr(input int i);
        return BASE + 32'(4 * ((i < 16) ? i : (1008 + i - 16)));
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          lat, first, second, pulses, cls, i;
        logic [31:0] rd, a, exp_rd, rd_b;
        logic        er, exp_err, er_b, we;

        vecs[0]  = '{1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h1001_0008, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h1001_0000, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h1001_0002, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h1001_1000, 32'h55AA_55AA, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h1001_0000, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h1000_FFFC, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h1001_0FFC, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 32'h1001_0010, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h1001_0FFE, 32'h0,         1'b1, 1'b1, 32'h0};

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(rdy2), 32'd0);
        chk("reset_error", 32'(err2), 32'd0);
        chk("reset_readdata", rd2, 32'h0);
        chk("reset_ready_l1", 32'(rdy1), 32'd0);
        chk("reset_readdata_l1", rd1, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int v = 0; v < 12; v++) begin
            run_req(1'b0, vecs[v].we, vecs[v].a, vecs[v].d, lat, rd, er);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_error", v), 32'(er), 32'(vecs[v].exp_err));
            if (vecs[v].chk_rd) chk($sformatf("vec%0d_readdata", v), rd, vecs[v].exp_rd);
            model_apply(vecs[v].we, vecs[v].a, vecs[v].d, exp_err, exp_rd);
        end
        @(posedge clk); #1;

        // req held high: store, then a load accepted only in the IDLE after DONE
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h1001_0020; wd2 = 32'h1111_2222;
        @(posedge clk); #1;
        we2 = 1'b0; wd2 = $urandom;
        first = 0; second = 0; pulses = 0; rd_b = '0; er_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 3) req2 = 1'b0;
            if (rdy2) begin
                pulses++;
                if (first == 0) first = k; else second = k;
                rd_b = rd2; er_b = err2;
            end
        end
        chk("held_first_ready_edge", 32'(first), 32'd2);
        chk("held_second_ready_edge", 32'(second), 32'd5);
        chk("held_pulse_count", 32'(pulses), 32'd2);
        chk("held_load_data", rd_b, 32'h1111_2222);
        chk("held_load_error", 32'(er_b), 32'd0);
        model_apply(1'b1, 32'h1001_0020, 32'h1111_2222, exp_err, exp_rd);
        model_apply(1'b0, 32'h1001_0020, 32'h0, exp_err, exp_rd);

        // Reset one cycle after acceptance aborts the store
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h1001_0010; wd2 = 32'h1234_5678;
        @(posedge clk); #1;
        req2 = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_readdata_reset", rd2, 32'h0);
        mdl_rd = 32'h0;
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (rdy2) pulses++;
        end
        chk("abort_no_ready", 32'(pulses), 32'd0);
        xact(1'b0, 32'h1001_0010, 32'h0);

        // LATENCY=1: back-to-back stores with req held
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h1001_0000; wd1 = 32'hA1A1_A1A1;
        @(posedge clk); #1;
        addr1 = 32'h1001_0004; wd1 = 32'hB2B2_B2B2;
        first = 0; second = 0; pulses = 0; er_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 2) req1 = 1'b0;
            if (rdy1) begin
                pulses++;
                if (first == 0) first = k; else second = k;
                er_b = er_b | err1;
            end
        end
        chk("l1_first_ready_edge", 32'(first), 32'd1);
        chk("l1_second_ready_edge", 32'(second), 32'd3);
        chk("l1_pulse_count", 32'(pulses), 32'd2);
        chk("l1_store_error", 32'(er_b), 32'd0);
        run_req(1'b1, 1'b0, 32'h1001_0000, 32'h0, lat, rd, er);
        chk("l1_load0_latency", 32'(lat), 32'd1);
        chk("l1_load0_data", rd, 32'hA1A1_A1A1);
        run_req(1'b1, 1'b0, 32'h1001_0004, 32'h0, lat, rd, er);
        chk("l1_load1_latency", 32'(lat), 32'd1);
        chk("l1_load1_data", rd, 32'hB2B2_B2B2);
        chk("l1_load1_error", 32'(er), 32'd0);
        @(posedge clk); #1;

        // Randomized traffic on the LATENCY=2 instance over a pre-written word pool
        for (int p = 0; p < 32; p++) xact(1'b1, pool_addr(p), $urandom);
        for (int t = 0; t < 80; t++) begin
            cls = $urandom_range(0, 5);
            i   = $urandom_range(0, 31);
            we  = 1'($urandom_range(0, 1));
            case (cls)
                3:       a = pool_addr(i) + 32'($urandom_range(1, 3));
                4:       a = BASE + 32'h1000 + 32'(4 * i);
                5:       a = BASE - 32'(4 * (i + 1));
                default: a = pool_addr(i);
            endcase
            xact(we, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
